// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants for the round-robin arbiter that fronts the 16-to-1
// single-bit mux tree. The Mux and the bench use the same values.
//   NUM_LEVELS : mux tree depth
//   WIDTH      : number of requesters / mux inputs
//   SEL_W      : select width
//   HOLD_W     : width of the per-grant hold counter (holds 1..15)
//   state_e    : arbiter state encoding
package mux_rr_arbiter_pkg;

  localparam int NUM_LEVELS = 5;
  localparam int WIDTH      = 2 ** (NUM_LEVELS - 1);
  localparam int SEL_W      = NUM_LEVELS - 1;
  localparam int HOLD_W     = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin search.
// Returns the first index i with req[i]=1 when scanning start, start+1, ...
// modulo WIDTH. The request vector is rotated so that 'start' lands on bit 0,
// the lowest set bit is priority-encoded, and the offset is added back to
// 'start'.
//   req   : request vector
//   start : first index to consider
//   idx   : winning index (0 when nothing is found)
//   found : high when any request is set
module rr_pick #(
  parameter int WIDTH = mux_rr_arbiter_pkg::WIDTH,
  parameter int SEL_W = mux_rr_arbiter_pkg::SEL_W
) (
  input  logic [WIDTH-1:0] req,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  import mux_rr_arbiter_pkg::*;

  logic [WIDTH-1:0] rot;
  logic [SEL_W-1:0] off;

  always_comb begin
    // Doubling the vector turns the right shift into a rotate.
    rot = WIDTH'({req, req} >> start);
    off = '0;
    // Descending scan so the lowest set bit wins.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    // WIDTH == 2**SEL_W, so the add wraps 15 back to 0 on its own.
    idx   = start + off;
    found = |req;
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing the 16-to-1 single-bit mux between WIDTH
// requesters. One requester is granted at a time; its index drives Mux.sel.
// A grant is limited to MAX_HOLD consecutive cycles while others wait.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   req   : level-sensitive request per requester
//   grant : registered one-hot grant, zero when idle
//   sel   : registered index of current or last grant (to Mux.sel)
//   busy  : high while a grant is active (|grant)
module mux_rr_arbiter #(
  parameter int NUM_LEVELS = 5,
  parameter int WIDTH      = 2 ** (NUM_LEVELS - 1),
  parameter int SEL_W      = NUM_LEVELS - 1,
  parameter int MAX_HOLD   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] grant,
  output logic [SEL_W-1:0] sel,
  output logic             busy
);

  import mux_rr_arbiter_pkg::*;

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  state_e            state, state_nx;
  logic [WIDTH-1:0]  grant_nx;
  logic [SEL_W-1:0]  sel_nx;
  logic [SEL_W-1:0]  ptr, ptr_nx;
  logic [HOLD_W-1:0] hold_cnt, hold_nx;

  logic [SEL_W-1:0]  sel_inc;
  logic [WIDTH-1:0]  sel_oh;
  logic              cur_req;
  logic              others;

  logic [SEL_W-1:0]  idle_idx, next_idx;
  logic              idle_found, next_found;

  assign sel_inc = sel + SEL_W'(1);
  assign sel_oh  = WIDTH'(1) << sel;
  assign cur_req = |(req & sel_oh);
  assign others  = |(req & ~sel_oh);

  // Search from the rotating pointer when starting from idle.
  rr_pick #(.WIDTH(WIDTH), .SEL_W(SEL_W)) u_pick_idle (
    .req   (req),
    .start (ptr),
    .idx   (idle_idx),
    .found (idle_found)
  );

  // Search from just past the current grant for hand-offs; this can only
  // come back to 'sel' when nobody else is requesting.
  rr_pick #(.WIDTH(WIDTH), .SEL_W(SEL_W)) u_pick_next (
    .req   (req),
    .start (sel_inc),
    .idx   (next_idx),
    .found (next_found)
  );

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    sel_nx   = sel;
    ptr_nx   = ptr;
    hold_nx  = hold_cnt;

    case (state)
      ST_IDLE: begin
        if (idle_found) begin
          grant_nx = WIDTH'(1) << idle_idx;
          sel_nx   = idle_idx;
          ptr_nx   = idle_idx + SEL_W'(1);
          hold_nx  = HOLD_W'(1);
          state_nx = ST_GRANT;
        end
      end

      ST_GRANT: begin
        // With cur_req low, next_found means someone else is waiting:
        // hand off with no idle cycle. With cur_req high, hand off only
        // once the hold budget is spent and a competitor exists.
        if ((!cur_req && next_found) ||
            (cur_req && (hold_cnt == HOLD_MAX) && others)) begin
          grant_nx = WIDTH'(1) << next_idx;
          sel_nx   = next_idx;
          ptr_nx   = next_idx + SEL_W'(1);
          hold_nx  = HOLD_W'(1);
        end else if (!cur_req) begin
          // Released with nobody waiting; sel keeps the last index.
          grant_nx = '0;
          state_nx = ST_IDLE;
        end else if (hold_cnt < HOLD_MAX) begin
          hold_nx = hold_cnt + HOLD_W'(1);
        end
      end

      default: begin
        grant_nx = '0;
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      grant    <= '0;
      sel      <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      sel      <= sel_nx;
      ptr      <= ptr_nx;
      hold_cnt <= hold_nx;
    end
  end

  assign busy = |grant;

  // Grant stays one-hot or zero, and always points at sel while busy.
  a_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_selgrant : assert property (@(posedge clk) disable iff (rst)
    busy |-> |(grant & sel_oh));

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

  import mux_rr_arbiter_pkg::*;

  localparam int MH = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] req;
  logic [WIDTH-1:0] grant;
  logic [SEL_W-1:0] sel;
  logic             busy;

  typedef struct packed {
    logic [WIDTH-1:0] grant;
    logic [SEL_W-1:0] sel;
    logic             busy;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic        m_state;
  logic [15:0] m_grant;
  int          m_sel;
  int          m_ptr;
  int          m_hold;

  logic [15:0] din = 16'hAAAA;
  logic        mux_out;
  assign mux_out = din[sel];

  mux_rr_arbiter #(.NUM_LEVELS(NUM_LEVELS), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .grant (grant),
    .sel   (sel),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input logic [15:0] r, input int start);
    for (int k = 0; k < 16; k++) begin
      if (r[(start + k) % 16]) return (start + k) % 16;
    end
    return -1;
  endfunction

  task automatic take(input int p);
    m_grant = 16'h1 << p;
    m_sel   = p;
    m_hold  = 1;
    m_ptr   = (p + 1) % 16;
    m_state = 1'b1;
  endtask

  // Drive one cycle of stimulus, advance the model and queue its outputs.
  task automatic step(input logic [15:0] r, input logic rs);
    int   p;
    int   g;
    logic oth;
    exp_t x;
    req = r;
    rst = rs;
    if (rs) begin
      m_state = 1'b0; m_grant = '0; m_sel = 0; m_ptr = 0; m_hold = 0;
    end else if (!m_state) begin
      p = pick(r, m_ptr);
      if (p >= 0) take(p);
    end else begin
      g   = m_sel;
      oth = (r & ~(16'h1 << g)) != 16'h0;
      if (!r[g] && oth) take(pick(r, (g + 1) % 16));
      else if (!r[g]) begin m_grant = '0; m_state = 1'b0; end
      else if (m_hold == MH && oth) take(pick(r, (g + 1) % 16));
      else if (m_hold < MH) m_hold++;
    end
    x.grant = m_grant;
    x.sel   = 4'(m_sel);
    x.busy  = (m_grant != 16'h0);
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(16'hFFFF, 1'b1);
      e = sb.pop_front();
      checks++;
      if ({grant, sel, busy} !== {e.grant, e.sel, e.busy} ||
          {grant, sel, busy} !== {16'h0, 4'd0, 1'b0}) begin
        failures++;
        $display("FAIL reset got grant=%h sel=%0d busy=%b need grant=0000 sel=0 busy=0",
                 grant, sel, busy);
      end
    end
    step(16'hFFFF, 1'b0);
    e = sb.pop_front();
    checks++;
    if ({grant, sel, busy} !== {e.grant, e.sel, e.busy} ||
        {grant, sel, busy} !== {16'h0001, 4'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_first_grant got grant=%h sel=%0d busy=%b need grant=0001 sel=0 busy=1",
               grant, sel, busy);
    end
    step(16'h0000, 1'b0);
    e = sb.pop_front();
    checks++;
    if ({grant, sel, busy} !== {e.grant, e.sel, e.busy}) begin
      failures++;
      $display("FAIL reset_release got grant=%h sel=%0d busy=%b need grant=%h sel=%0d busy=%b",
               grant, sel, busy, e.grant, e.sel, e.busy);
    end
  endtask

  task automatic test_single();
    step(16'h0400, 1'b0);
    e = sb.pop_front();
    checks++;
    if ({grant, sel, busy} !== {e.grant, e.sel, e.busy} ||
        {grant, sel, busy} !== {16'h0400, 4'd10, 1'b1}) begin
      failures++;
      $display("FAIL single_grant got grant=%h sel=%0d busy=%b need grant=0400 sel=10 busy=1",
               grant, sel, busy);
    end
    step(16'h0000, 1'b0);
    e = sb.pop_front();
    checks++;
    if ({grant, sel, busy} !== {e.grant, e.sel, e.busy} ||
        {grant, sel, busy} !== {16'h0000, 4'd10, 1'b0}) begin
      failures++;
      $display("FAIL single_release got grant=%h sel=%0d busy=%b need grant=0000 sel=10 busy=0",
               grant, sel, busy);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] want_sel;
    step(16'h0000, 1'b1);
    e = sb.pop_front();
    for (int k = 0; k < 12; k++) begin
      step(16'h8001, 1'b0);
      e = sb.pop_front();
      want_sel = ((k / MH) % 2) ? 4'd15 : 4'd0;
      checks++;
      if ({grant, sel, busy} !== {e.grant, e.sel, e.busy} || sel !== want_sel ||
          !$onehot(grant)) begin
        failures++;
        $display("FAIL rotation[%0d] got grant=%h sel=%0d busy=%b need grant=%h sel=%0d busy=1",
                 k, grant, sel, busy, e.grant, want_sel);
      end
      checks++;
      if (mux_out !== want_sel[0]) begin
        failures++;
        $display("FAIL mux_out[%0d] got %b need %b", k, mux_out, want_sel[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rv [6] = '{16'h8000, 16'h8000, 16'h8000, 16'h0009, 16'h0008, 16'h0000};
    logic [3:0]  sv [6] = '{4'd15, 4'd15, 4'd15, 4'd0, 4'd3, 4'd3};
    logic        bv [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 6; k++) begin
      step(rv[k], 1'b0);
      e = sb.pop_front();
      checks++;
      if ({grant, sel, busy} !== {e.grant, e.sel, e.busy} || sel !== sv[k] || busy !== bv[k]) begin
        failures++;
        $display("FAIL back_to_back[%0d] got grant=%h sel=%0d busy=%b need sel=%0d busy=%b",
                 k, grant, sel, busy, sv[k], bv[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(16'h0080, 1'b0);
    e = sb.pop_front();
    checks++;
    if ({grant, sel, busy} !== {e.grant, e.sel, e.busy} || sel !== 4'd7) begin
      failures++;
      $display("FAIL mid_setup got grant=%h sel=%0d need grant=0080 sel=7", grant, sel);
    end
    step(16'h0090, 1'b1);
    e = sb.pop_front();
    checks++;
    if ({grant, sel, busy} !== {e.grant, e.sel, e.busy} ||
        {grant, sel, busy} !== {16'h0000, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL mid_reset got grant=%h sel=%0d busy=%b need grant=0000 sel=0 busy=0",
               grant, sel, busy);
    end
    step(16'h0090, 1'b0);
    e = sb.pop_front();
    checks++;
    if ({grant, sel, busy} !== {e.grant, e.sel, e.busy} ||
        {grant, sel, busy} !== {16'h0010, 4'd4, 1'b1}) begin
      failures++;
      $display("FAIL mid_after got grant=%h sel=%0d busy=%b need grant=0010 sel=4 busy=1",
               grant, sel, busy);
    end
    step(16'h0000, 1'b0);
    e = sb.pop_front();
  endtask

  task automatic test_random();
    logic [15:0] r;
    logic        rs;
    for (int k = 0; k < 400; k++) begin
      r  = 16'($urandom) & 16'($urandom) & 16'($urandom);
      rs = ($urandom_range(0, 49) == 0);
      step(r, rs);
      e = sb.pop_front();
      checks++;
      if ({grant, sel, busy} !== {e.grant, e.sel, e.busy}) begin
        failures++;
        $display("FAIL random[%0d] req=%h got grant=%h sel=%0d busy=%b need grant=%h sel=%0d busy=%b",
                 k, r, grant, sel, busy, e.grant, e.sel, e.busy);
      end
      checks++;
      if (busy && grant[sel] !== 1'b1) begin
        failures++;
        $display("FAIL random_selgrant[%0d] got grant=%h sel=%0d need grant[sel]=1", k, grant, sel);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    test_reset();
    test_single();
    test_rotation();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares the 16-to-1 single-bit mux (Mux) between WIDTH requesters.
- Each requester raises a request line. The arbiter grants one requester at a time and drives the mux select with the granted index.
- A hold counter limits each grant to MAX_HOLD cycles while others are waiting.
- Sits directly in front of the Mux instance; its sel output connects to Mux.sel.

Parameters:
- NUM_LEVELS, 5: mux tree depth, matching the Mux parameter.
- WIDTH, 2**(NUM_LEVELS-1) = 16: number of requesters and mux inputs.
- SEL_W, NUM_LEVELS-1 = 4: select width.
- MAX_HOLD, 4: maximum consecutive cycles per grant while other requests are pending. Legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  WIDTH  request per requester; level-sensitive, held high until done.
- grant  output  WIDTH  one-hot grant, or all-zero when idle; registered.
- sel  output  SEL_W  index of current or last grant; drives Mux.sel; registered.
- busy  output  1  high while any grant is active; equals |grant.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset state: state=IDLE, grant=0, sel=0, busy=0, ptr=0, hold_cnt=0. rst overrides all other inputs in the same edge.
- States: IDLE and GRANT. All outputs are registered; there is no combinational path from req to any output.
- Search function pick(start): returns the first index i with req[i]=1, scanning start, start+1, … modulo WIDTH (15 wraps to 0). Returns "none" if req==0.

IDLE:
- If req!=0: next edge grant=onehot(pick(ptr)), sel=that index, busy=1, hold_cnt=1, ptr=index+1 mod WIDTH, go to GRANT.
- Request-to-grant latency is exactly 1 cycle.
- If req==0: stay in IDLE; outputs unchanged; sel keeps its last value.

GRANT (current index g=sel), evaluated each edge, first match wins:
- a) req[g]==0 and other requests pending: switch to pick(g+1) on the same edge. Back-to-back, with no idle cycle. hold_cnt=1, ptr updated.
- b) req[g]==0 and req==0: grant=0, busy=0, go to IDLE. sel holds g.
- c) req[g]==1, hold_cnt==MAX_HOLD, and any req[j]==1 with j!=g: rotate to pick(g+1), hold_cnt=1, ptr updated.
- d) req[g]==1, otherwise: keep grant. hold_cnt increments, saturating at MAX_HOLD. With no competitors the grant is held indefinitely.

Invariants and boundaries:
- Fairness: pick(g+1) never returns g while another requester is pending. Worst-case wait is (WIDTH-1)*MAX_HOLD cycles.
- Invariant: grant is one-hot or zero. When busy=1, grant[sel]=1.
- A request appearing in the same cycle another is released is eligible in that edge's search.
- Reset mid-grant: the next edge forces the reset state. The grant drops with no release handshake, and ptr returns to 0.
- MAX_HOLD=1 gives pure per-cycle round-robin under contention.

Decomposition:
- Shared package/include: constants NUM_LEVELS, WIDTH, SEL_W, and state encodings ST_IDLE=1'b0, ST_GRANT=1'b1. Reused by Mux and the bench.
- Sub-module: rr_pick, combinational. Inputs are req[WIDTH-1:0] and start[SEL_W-1:0]. Outputs are idx[SEL_W-1:0] and found. Implemented as a rotate, then priority-encode, then rotate back. The arbiter instantiates it twice: start=ptr for IDLE and start=sel+1 for GRANT.
- The Mux stays external and unchanged.

Test Plan:
- Reset: rst=1 for 2 cycles with req=16'hFFFF. Required: grant=0, sel=0, busy=0 throughout. After rst drops, first grant is 16'h0001, sel=0, one cycle later.
- Single request: req=16'h0400. Required: grant=16'h0400, sel=10, busy=1 after 1 edge. Then drop req; next edge grant=0, busy=0, sel stays 10.
- Contention rotation: req=16'h8001 held, MAX_HOLD=4. Required sel sequence 0,0,0,0,15,15,15,15,0,0,… with grant one-hot every cycle.
- Wrap and back-to-back: hold grant on 15, then set req=16'h0009 and drop bit 15. Required: next edge sel=0 (wraps 15 to 0), no idle cycle. Drop bit 0; next edge sel=3.
- Reset mid-grant: grant active on sel=7, assert rst for 1 cycle with req=16'h0090 held. Required: next edge grant=0, busy=0, sel=0. After release, grant=16'h0010 (sel=4), since ptr was reset to 0.
- Integration with Mux: in=16'hAAAA and arbiter sel driving Mux under scenario 3. Required: Mux out=in[sel], i.e. 0 for sel=0 and 1 for sel=15, each cycle.
